// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU operation codes, FSM encoding and opcode classifiers for
// the ALU command sequencer.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND16 = 3'b000;
    localparam logic [2:0] OP_OR16  = 3'b001;
    localparam logic [2:0] OP_ADD16 = 3'b010;
    localparam logic [2:0] OP_SUB16 = 3'b011;
    localparam logic [2:0] OP_ADD32 = 3'b100;
    localparam logic [2:0] OP_SUB32 = 3'b101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StExecLo = 2'd1,
        StExecHi = 2'd2,
        StResp   = 2'd3
    } seq_state_e;

    function automatic logic is_legal(input logic [2:0] op);
        return (op != 3'b110) && (op != 3'b111);
    endfunction

    function automatic logic is_sub(input logic [2:0] op);
        return (op == OP_SUB16) || (op == OP_SUB32);
    endfunction

    function automatic logic is_wide(input logic [2:0] op);
        return (op == OP_ADD32) || (op == OP_SUB32);
    endfunction

    function automatic logic is_logic(input logic [2:0] op);
        return (op == OP_AND16) || (op == OP_OR16);
    endfunction

    function automatic logic [2:0] alu_op_for(input logic [2:0] op);
        case (op)
            OP_AND16: return ALU_AND;
            OP_OR16:  return ALU_OR;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_flags.sv
// Status flag derivation for a finished operation: zero, final carry and
// signed overflow, with carry/overflow suppressed for logical ops.
module alu_seq_flags #(
    parameter int unsigned W = 32
) (
    input  logic         a_msb,
    input  logic         beff_msb,
    input  logic         res_msb,
    input  logic [W-1:0] result,
    input  logic         carry_raw,
    input  logic         is_logic,
    output logic         zero,
    output logic         carry,
    output logic         overflow
);

    assign zero     = (result == '0);
    assign carry    = is_logic ? 1'b0 : carry_raw;
    // Same-sign operands producing a result of the other sign.
    assign overflow = is_logic ? 1'b0 : ((a_msb == beff_msb) && (res_msb != a_msb));

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for a 16-bit ALU slice: decodes commands into ALU controls,
// chains two passes for 32-bit add/sub, and returns result plus flags.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned ALU_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [2*ALU_W-1:0] cmd_a,
    input  logic [2*ALU_W-1:0] cmd_b,
    output logic [ALU_W-1:0]   alu_a,
    output logic [ALU_W-1:0]   alu_b,
    output logic               alu_b_invert,
    output logic               alu_carry_in,
    output logic [2:0]         alu_operation,
    input  logic [ALU_W-1:0]   alu_result,
    input  logic               alu_carry_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*ALU_W-1:0] rsp_result,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic               rsp_overflow,
    output logic               rsp_err
);

    localparam int unsigned W = 2 * ALU_W;

    seq_state_e       state;
    logic [2:0]       op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [ALU_W-1:0] res_lo_q;

    logic [W-1:0] fin_result;
    logic         fin_a_msb;
    logic         fin_beff_msb;
    logic         op_logic;
    logic         load_rsp;
    logic         f_zero;
    logic         f_carry;
    logic         f_overflow;

    assign cmd_ready = (state == StIdle);
    assign op_logic  = is_logic(op_q);
    assign load_rsp  = ((state == StExecLo) && !is_wide(op_q)) || (state == StExecHi);

    // Final result as it will look once the current ALU pass is captured.
    always_comb begin
        fin_result   = {{ALU_W{1'b0}}, alu_result};
        fin_a_msb    = a_q[ALU_W-1];
        fin_beff_msb = b_q[ALU_W-1] ^ is_sub(op_q);
        if (state == StExecHi) begin
            fin_result   = {alu_result, res_lo_q};
            fin_a_msb    = a_q[W-1];
            fin_beff_msb = b_q[W-1] ^ is_sub(op_q);
        end
    end

    alu_seq_flags #(
        .W(W)
    ) u_flags (
        .a_msb    (fin_a_msb),
        .beff_msb (fin_beff_msb),
        .res_msb  (alu_result[ALU_W-1]),
        .result   (fin_result),
        .carry_raw(alu_carry_out),
        .is_logic (op_logic),
        .zero     (f_zero),
        .carry    (f_carry),
        .overflow (f_overflow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= StIdle;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_lo_q      <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_b_invert  <= 1'b0;
            alu_carry_in  <= 1'b0;
            alu_operation <= ALU_AND;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_carry     <= 1'b0;
            rsp_zero      <= 1'b0;
            rsp_overflow  <= 1'b0;
            rsp_err       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        a_q  <= cmd_a;
                        b_q  <= cmd_b;
                        if (is_legal(cmd_op)) begin
                            state         <= StExecLo;
                            alu_a         <= cmd_a[ALU_W-1:0];
                            alu_b         <= cmd_b[ALU_W-1:0];
                            alu_b_invert  <= is_sub(cmd_op);
                            alu_carry_in  <= is_sub(cmd_op);
                            alu_operation <= alu_op_for(cmd_op);
                        end else begin
                            state        <= StResp;
                            rsp_valid    <= 1'b1;
                            rsp_result   <= '0;
                            rsp_carry    <= 1'b0;
                            rsp_zero     <= 1'b0;
                            rsp_overflow <= 1'b0;
                            rsp_err      <= 1'b1;
                        end
                    end
                end
                StExecLo: begin
                    res_lo_q <= alu_result;
                    if (is_wide(op_q)) begin
                        state        <= StExecHi;
                        alu_a        <= a_q[W-1:ALU_W];
                        alu_b        <= b_q[W-1:ALU_W];
                        alu_carry_in <= alu_carry_out;
                    end
                end
                StExecHi: begin
                    // Transition to StResp is handled by the load_rsp path below.
                end
                StResp: begin
                    if (rsp_ready) begin
                        state        <= StIdle;
                        rsp_valid    <= 1'b0;
                        rsp_result   <= '0;
                        rsp_carry    <= 1'b0;
                        rsp_zero     <= 1'b0;
                        rsp_overflow <= 1'b0;
                        rsp_err      <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase

            if (load_rsp) begin
                state         <= StResp;
                alu_a         <= '0;
                alu_b         <= '0;
                alu_b_invert  <= 1'b0;
                alu_carry_in  <= 1'b0;
                alu_operation <= ALU_AND;
                rsp_valid     <= 1'b1;
                rsp_result    <= fin_result;
                rsp_carry     <= f_carry;
                rsp_zero      <= f_zero;
                rsp_overflow  <= f_overflow;
                rsp_err       <= 1'b0;
            end
        end
    end

endmodule
